// File: rtl/seg_scan_dim.sv
// seg_scan_dim: 6-digit time-multiplexed 7-seg driver with frame-coherent latching,
// anti-ghosting dead time and optional PWM dimming (define SEG_DIM_EN to enable).
`timescale 1ns/1ps
module seg_scan_dim #(
  parameter int SCAN_DIV = 49_999,
  parameter int DEAD_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_data0,
  input  logic [7:0] seg_data1,
  input  logic [7:0] seg_data2,
  input  logic [7:0] seg_data3,
  input  logic [7:0] seg_data4,
  input  logic [7:0] seg_data5,
  input  logic       blank,
`ifdef SEG_DIM_EN
  input  logic [3:0] brightness,
`endif
  output logic [5:0] seg_sel,
  output logic [7:0] seg_data,
  output logic       frame_start
);

  localparam int               CNT_W    = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYC);
  localparam logic [2:0]       IDX_LAST = 3'd5;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shadow [6];
  logic             slot_end;
  logic             frame_end;
  logic             pwm_ok;
  logic             lit;
  logic [7:0]       cur_code;

  function automatic logic [5:0] digit_sel(input logic [2:0] i);
    return ~(6'b000001 << i);
  endfunction

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // slot prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end
    end
  end

  // frame latch: inputs are only sampled at the end of the last digit's slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= 8'hFF;
      end
    end else if (frame_end) begin
      shadow[0] <= seg_data0;
      shadow[1] <= seg_data1;
      shadow[2] <= seg_data2;
      shadow[3] <= seg_data3;
      shadow[4] <= seg_data4;
      shadow[5] <= seg_data5;
    end
  end

`ifdef SEG_DIM_EN
  logic [3:0] pwm;
  logic [3:0] bri_q;

  // brightness is held per slot so a digit never changes duty mid-slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm   <= 4'h0;
      bri_q <= 4'hF;
    end else begin
      pwm <= pwm + 4'h1;
      if (slot_end) begin
        bri_q <= brightness;
      end
    end
  end

  assign pwm_ok = (pwm <= bri_q);
`else
  assign pwm_ok = 1'b1;
`endif

  always_comb begin
    cur_code = 8'hFF;
    case (idx)
      3'd0:    cur_code = shadow[0];
      3'd1:    cur_code = shadow[1];
      3'd2:    cur_code = shadow[2];
      3'd3:    cur_code = shadow[3];
      3'd4:    cur_code = shadow[4];
      3'd5:    cur_code = shadow[5];
      default: cur_code = 8'hFF;
    endcase
  end

  assign lit = !blank && (cnt >= CNT_DEAD) && pwm_ok;

  // registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel     <= 6'h3F;
      seg_data    <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      seg_sel     <= lit ? digit_sel(idx) : 6'h3F;
      seg_data    <= lit ? cur_code : 8'hFF;
      frame_start <= frame_end;
    end
  end

  a_one_digit: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~seg_sel));
  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n) idx <= IDX_LAST);

endmodule
